drf_io_bank: RTL

- Parametrised I/O port bank replacing the fixed 4-bit input/output ports of the DRF system.
- Provides NUM_PORTS channels of PORT_WIDTH bits each: latched outputs, synchronised inputs, sticky change-detect flags with per-bit masks, and a registered interrupt.
- Sits between the CPU core's I/O bus (8-bit data) and the FPGA pins.

---
 rtl/drf_io_bank.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/drf_io_bank.sv
// drf_io_bank: bank of NUM_PORTS latched output ports and synchronised,
// change-flagged input ports behind the DRF core's 8-bit register bus.
module drf_io_bank #(
  parameter int NUM_PORTS   = 4,
  parameter int PORT_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  localparam int ADDR_WIDTH = $clog2(NUM_PORTS) + 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*PORT_WIDTH-1:0] port_input,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] port_output,
  input  logic [ADDR_WIDTH-1:0]           bus_addr,
  input  logic                            bus_wr_en,
  input  logic [7:0]                      bus_wr_data,
  input  logic                            bus_rd_en,
  output logic [7:0]                      bus_rd_data,
  output logic                            bus_rd_valid,
  output logic                            irq
);

  localparam int TOTAL_W = NUM_PORTS * PORT_WIDTH;
  localparam int IDX_W   = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;
  localparam logic [IDX_W:0] PORT_COUNT = (IDX_W + 1)'(NUM_PORTS);

  localparam logic [1:0] SEL_OUT  = 2'd0;
  localparam logic [1:0] SEL_IN   = 2'd1;
  localparam logic [1:0] SEL_FLAG = 2'd2;
  localparam logic [1:0] SEL_MASK = 2'd3;

  logic [IDX_W-1:0]      ch_idx_s;
  logic [1:0]            reg_sel_s;
  logic                  in_range_s;
  logic [PORT_WIDTH-1:0] wr_field_s;
  logic                  unused_wr_bits_s;

  logic [TOTAL_W-1:0]    sync_r [SYNC_STAGES];
  logic [TOTAL_W-1:0]    sync_last_s;
  logic [TOTAL_W-1:0]    prev_r;
  logic [TOTAL_W-1:0]    chg_s;
  logic [TOTAL_W-1:0]    out_r;
  logic [TOTAL_W-1:0]    mask_r;
  logic [TOTAL_W-1:0]    flag_r;
  logic [TOTAL_W-1:0]    out_next_s;
  logic [TOTAL_W-1:0]    mask_next_s;
  logic [TOTAL_W-1:0]    flag_next_s;
  logic [TOTAL_W-1:0]    w1c_s;
  logic [NUM_PORTS-1:0]  hit_s;

  logic [PORT_WIDTH-1:0] out_ch_s  [NUM_PORTS];
  logic [PORT_WIDTH-1:0] in_ch_s   [NUM_PORTS];
  logic [PORT_WIDTH-1:0] flag_ch_s [NUM_PORTS];
  logic [PORT_WIDTH-1:0] mask_ch_s [NUM_PORTS];
  logic [PORT_WIDTH-1:0] rd_field_s;
  logic [7:0]            rd_word_s;

  logic                  irq_r;
  logic [7:0]            rd_data_r;
  logic                  rd_valid_r;

  // A single-channel bank has no channel-index field in the address.
  if (ADDR_WIDTH > 2) begin : g_idx
    assign ch_idx_s = bus_addr[ADDR_WIDTH-1:2];
  end else begin : g_idx_single
    assign ch_idx_s = '0;
  end

  assign reg_sel_s        = bus_addr[1:0];
  assign in_range_s       = ({1'b0, ch_idx_s} < PORT_COUNT);
  assign wr_field_s       = bus_wr_data[PORT_WIDTH-1:0];
  assign unused_wr_bits_s = ^bus_wr_data;

  assign sync_last_s = sync_r[SYNC_STAGES-1];
  assign chg_s       = sync_last_s ^ prev_r;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_ch
    assign hit_s[k] = bus_wr_en && in_range_s && (ch_idx_s == IDX_W'(k));

    assign out_next_s[k*PORT_WIDTH +: PORT_WIDTH] =
      (hit_s[k] && (reg_sel_s == SEL_OUT)) ? wr_field_s : out_r[k*PORT_WIDTH +: PORT_WIDTH];
    assign mask_next_s[k*PORT_WIDTH +: PORT_WIDTH] =
      (hit_s[k] && (reg_sel_s == SEL_MASK)) ? wr_field_s : mask_r[k*PORT_WIDTH +: PORT_WIDTH];
    assign w1c_s[k*PORT_WIDTH +: PORT_WIDTH] =
      (hit_s[k] && (reg_sel_s == SEL_FLAG)) ? wr_field_s : {PORT_WIDTH{1'b0}};

    assign out_ch_s[k]  = out_r[k*PORT_WIDTH +: PORT_WIDTH];
    assign in_ch_s[k]   = sync_last_s[k*PORT_WIDTH +: PORT_WIDTH];
    assign flag_ch_s[k] = flag_r[k*PORT_WIDTH +: PORT_WIDTH];
    assign mask_ch_s[k] = mask_r[k*PORT_WIDTH +: PORT_WIDTH];
  end

  // A fresh change outranks a simultaneous write-1-to-clear on the same bit.
  assign flag_next_s = (flag_r & ~w1c_s) | chg_s;

  // Read multiplexer over the pre-write register contents
  always_comb begin
    rd_field_s = {PORT_WIDTH{1'b0}};
    if (in_range_s) begin
      case (reg_sel_s)
        SEL_OUT:  rd_field_s = out_ch_s[ch_idx_s];
        SEL_IN:   rd_field_s = in_ch_s[ch_idx_s];
        SEL_FLAG: rd_field_s = flag_ch_s[ch_idx_s];
        SEL_MASK: rd_field_s = mask_ch_s[ch_idx_s];
        default:  rd_field_s = {PORT_WIDTH{1'b0}};
      endcase
    end else begin
      rd_field_s = {PORT_WIDTH{1'b0}};
    end
    rd_word_s = 8'(rd_field_s);
  end

  // Input synchroniser chain and previous-sample register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
      prev_r <= '0;
    end else begin
      sync_r[0] <= port_input;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_last_s;
    end
  end

  // Channel state registers and the interrupt level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r  <= '0;
      mask_r <= '0;
      flag_r <= '0;
      irq_r  <= 1'b0;
    end else begin
      out_r  <= out_next_s;
      mask_r <= mask_next_s;
      flag_r <= flag_next_s;
      irq_r  <= |(flag_r & mask_r);
    end
  end

  // Registered read port: data holds between reads, valid pulses once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r  <= 8'h00;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= bus_rd_en;
      if (bus_rd_en) begin
        rd_data_r <= rd_word_s;
      end
    end
  end

  assign port_output  = out_r;
  assign bus_rd_data  = rd_data_r;
  assign bus_rd_valid = rd_valid_r;
  assign irq          = irq_r;

endmodule
